// File: rtl/psum_accum_drain.sv
// psum_accum_drain: accumulates PASSES consecutive 16-bit partial sums from the
// last PE into one ACC_W-bit result, buffers results in a DEPTH-entry FIFO and
// drains them over a valid/ready handshake.
//
// Optional feature macro: PSUM_SAT_EN
//   defined   -> every addition saturates at 2^ACC_W-1 and sets sticky sat_flag
//   undefined -> additions wrap mod 2^ACC_W, sat_flag stays 0
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | pass_idx==0, no partial sum held
// ACCUM | a partial sum is held in acc
module psum_accum_drain #(
  parameter int PASSES = 3,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [15:0]              psum_in,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic                     flush,
  output logic [ACC_W-1:0]         res_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sat_flag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PASSES - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [IW-1:0]    pass_idx;
  logic [ACC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             accept;
  logic             do_flush;
  logic             group_done;
  logic             push;
  logic             pop;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             sat_hit;
  logic [ACC_W-1:0] push_data;

  assign psum_ready = (count != CW'(DEPTH));
  assign res_valid  = (count != '0);
  // Head is only meaningful while valid; show zero otherwise so a cleared block reads 0.
  assign res_out    = res_valid ? mem[rd_ptr] : '0;

  assign accept   = psum_valid && psum_ready;
  // flush is only honoured while the block can accept; the sender holds it otherwise.
  assign do_flush = flush && psum_ready;
  assign pop      = res_valid && res_ready;
  assign base     = (state == ACCUM) ? acc : '0;

`ifdef PSUM_SAT_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {1'b0, base} + (ACC_W+1)'(psum_in);
  assign sat_hit  = sum_wide[ACC_W];
  assign sum      = sat_hit ? '1 : sum_wide[ACC_W-1:0];
`else
  assign sat_hit  = 1'b0;
  assign sum      = base + ACC_W'(psum_in);
`endif

  assign group_done = (PASSES == 1) || ((state == ACCUM) && (pass_idx == LAST_IDX));
  // A flush with an accept folds the new psum in first; a lone flush closes the held partial.
  assign push       = (accept && (group_done || do_flush)) ||
                      (do_flush && !accept && (state == ACCUM));
  assign push_data  = accept ? sum : acc;

  // Group FSM: tracks pass position and the running partial sum.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      pass_idx <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (push) begin
        state    <= IDLE;
        pass_idx <= '0;
      end else if (accept) begin
        state    <= ACCUM;
        acc      <= sum;
        pass_idx <= pass_idx + 1'b1;
      end
      if (accept && sat_hit) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // Result storage; left unreset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_drain.sv
// Self-checking bench for psum_accum_drain (ACC_W=16 so saturation is reachable).
module tb_psum_accum_drain;

  localparam int PASSES = 3;
  localparam int DEPTH  = 4;
  localparam int ACC_W  = 16;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;
`ifdef PSUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk;
  logic              clear;
  logic [15:0]       psum_in;
  logic              psum_valid;
  logic              psum_ready;
  logic              flush;
  logic [ACC_W-1:0]  res_out;
  logic              res_valid;
  logic              res_ready;
  logic [$clog2(DEPTH):0] count;
  logic              sat_flag;

  psum_accum_drain #(.PASSES(PASSES), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .clear(clear), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .flush(flush), .res_out(res_out),
    .res_valid(res_valid), .res_ready(res_ready), .count(count),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops[$];
  int accepts = 0;

  typedef struct {
    bit v; int ps; bit fl; bit rr;
    int e_cnt; bit e_rv; int e_out;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Records handshakes seen before the edge, then advances to 1 time unit past it.
  task automatic tick();
    if (res_valid && res_ready) pops.push_back(int'(res_out));
    if (psum_valid && psum_ready) accepts++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; psum_valid = 1'b0; flush = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint g;
    int n;
    longint q[$];
    bit sat_m;
    bit ok;

    clear = 1'b1; psum_in = 16'd55; psum_valid = 1'b1; flush = 1'b1; res_ready = 1'b0;
    #1;
    // Reset with inputs active
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_psum_ready", psum_ready, 1);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_res_out", res_out, 0);
    clear = 1'b0; psum_valid = 1'b0; flush = 1'b0;
    tick();
    chk("rst_no_push", count, 0);

    // Table: back-to-back group, then flush cases
    vt[0]  = '{1, 100, 0, 1, 0, 0, 0};
    vt[1]  = '{1, 200, 0, 1, 0, 0, 0};
    vt[2]  = '{1, 300, 0, 1, 1, 1, 600};
    vt[3]  = '{0, 0,   0, 1, 0, 0, 0};
    vt[4]  = '{1, 7,   0, 1, 0, 0, 0};
    vt[5]  = '{1, 8,   0, 1, 0, 0, 0};
    vt[6]  = '{0, 0,   1, 1, 1, 1, 15};
    vt[7]  = '{1, 1,   0, 1, 0, 0, 0};
    vt[8]  = '{1, 2,   0, 1, 0, 0, 0};
    vt[9]  = '{1, 3,   0, 1, 1, 1, 6};
    vt[10] = '{1, 9,   1, 1, 1, 1, 9};
    vt[11] = '{0, 0,   0, 1, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      psum_valid = vt[i].v; psum_in = 16'(vt[i].ps);
      flush = vt[i].fl; res_ready = vt[i].rr;
      tick();
      chk($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d_res_valid", i), res_valid, vt[i].e_rv);
      if (vt[i].e_rv) chk($sformatf("vec%0d_res_out", i), res_out, vt[i].e_out);
    end
    psum_valid = 1'b0; flush = 1'b0;

    // Backpressure: 15 psums of 1, consumer stalled
    res_ready = 1'b0; psum_in = 16'd1; psum_valid = 1'b1; accepts = 0;
    for (int c = 0; c < 40 && accepts < 12; c++) tick();
    chk("bp_accepts_full", accepts, 12);
    chk("bp_count_full", count, 4);
    chk("bp_psum_ready", psum_ready, 0);
    chk("bp_head", res_out, 3);
    tick(); tick(); tick();
    chk("bp_stall_accepts", accepts, 12);
    chk("bp_stall_count", count, 4);
    res_ready = 1'b1; pops.delete();
    for (int c = 0; c < 40 && !(accepts == 15 && count == 0); c++) begin
      psum_valid = (accepts < 15);
      tick();
    end
    psum_valid = 1'b0;
    chk("bp_accepts_total", accepts, 15);
    chk("bp_pops", pops.size(), 5);
    foreach (pops[k]) chk($sformatf("bp_pop%0d", k), pops[k], 3);
    chk("bp_count_end", count, 0);

    // Saturation / wrap
    do_clear();
    res_ready = 1'b0;
    psum_valid = 1'b1;
    psum_in = 16'hFFFF; tick();
    psum_in = 16'h0002; tick();
    psum_in = 16'h0000; tick();
    psum_valid = 1'b0;
    chk("sat_count", count, 1);
    chk("sat_res_out", res_out, SAT ? 32'hFFFF : 32'h0001);
    chk("sat_flag", sat_flag, SAT ? 1 : 0);

    // Mid-group clear
    do_clear();
    chk("clr_sat_flag", sat_flag, 0);
    psum_valid = 1'b1; psum_in = 16'd50; tick();
    do_clear();
    chk("clr_count", count, 0);
    psum_valid = 1'b1;
    psum_in = 16'd10; tick();
    psum_in = 16'd20; tick();
    psum_in = 16'd30; tick();
    psum_valid = 1'b0; tick();
    chk("clr_res_count", count, 1);
    chk("clr_res_valid", res_valid, 1);
    chk("clr_res_out", res_out, 60);

    // Randomized run against a group/queue reference model
    do_clear();
    g = 0; n = 0; sat_m = 1'b0; q.delete();
    for (int c = 0; c < 500; c++) begin
      bit v, f, rr, rdy, acc_e, fl_e;
      longint ps, s;
      chk("rnd_count", count, q.size());
      chk("rnd_psum_ready", psum_ready, q.size() != DEPTH);
      chk("rnd_res_valid", res_valid, q.size() != 0);
      if (q.size() != 0) chk("rnd_res_out", res_out, 32'(q[0]));
      chk("rnd_sat_flag", sat_flag, sat_m);

      v  = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 9) < 4);
      ps = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, 65535))
                                        : longint'($urandom_range(0, 300));
      psum_valid = v; flush = f; res_ready = rr; psum_in = 16'(ps);

      rdy   = (q.size() != DEPTH);
      acc_e = v && rdy;
      fl_e  = f && rdy;
      if (rr && q.size() != 0) void'(q.pop_front());
      if (acc_e) begin
        s = ((n == 0) ? 0 : g) + ps;
        if (s > MAXV) begin
          if (SAT) begin
            s = MAXV;
            sat_m = 1'b1;
          end else begin
            s = s - (MAXV + 1);
          end
        end
        g = s;
        n++;
        if (n == PASSES || fl_e) begin
          q.push_back(g);
          n = 0;
        end
      end else if (fl_e && n > 0) begin
        q.push_back(g);
        n = 0;
      end
      tick();
    end
    psum_valid = 1'b0; flush = 1'b0;

    ok = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accum_drain.md
Name: psum_accum_drain

Overview:
- Downstream stage of the PE chain. Consumes the 16-bit partial sums leaving the last PE and accumulates PASSES consecutive partial sums, one per kernel pass, into one wider result.
- Completed results are buffered in a DEPTH-entry FIFO and drained over a valid/ready handshake to the output writer.
- Decouples the free-running PE pipeline from a stalling consumer.

Parameters:
- PASSES, 3, partial sums accumulated per result (>=1)
- DEPTH, 4, result FIFO entries (power of 2, >=2)
- ACC_W, 20, accumulator/result width (>=16)

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset
- psum_in  input  16  unsigned partial sum from last PE
- psum_valid  input  1  psum_in valid
- psum_ready  output  1  block can accept psum_in
- flush  input  1  close the current partial group early
- res_out  output  ACC_W  FIFO head result
- res_valid  output  1  res_out valid
- res_ready  input  1  consumer accepts res_out
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- sat_flag  output  1  sticky saturation indicator

Behaviour:
- Only clk is a clock; clear is synchronous and active-high.
- While clear=1 at a rising edge:
  - acc=0, pass_idx=0, state=IDLE.
  - FIFO read and write pointers = 0, count=0.
  - res_valid=0, res_out=0, sat_flag=0.
  - All inputs are ignored that cycle.
- psum_ready = (count != DEPTH). It is combinational from registered state and does not depend on psum_valid.
- Accept: psum_valid && psum_ready. Pop: res_valid && res_ready. res_valid = (count != 0). res_out is the FIFO head, held stable while res_valid=1 and res_ready=0.
- psum_in is zero-extended to ACC_W. sum = (pass_idx==0 ? 0 : acc) + ext(psum_in), mod 2^ACC_W.
- FSM states:
  - IDLE: pass_idx==0, no partial held.
  - ACCUM: a partial is held in acc.
- IDLE + accept:
  - If PASSES==1, push sum and stay in IDLE.
  - Otherwise acc=sum, pass_idx=1, go to ACCUM.
- ACCUM + accept:
  - If pass_idx==PASSES-1, push sum, pass_idx=0, go to IDLE.
  - Otherwise acc=sum, pass_idx+=1.
- flush (sampled only when psum_ready=1):
  - In ACCUM with no accept: push acc, go to IDLE.
  - In ACCUM with accept: the accepted psum is included first, then sum is pushed and the block goes to IDLE.
  - In IDLE with no accept: no-op.
  - In IDLE with accept: push sum immediately as a one-pass result.
  - flush while psum_ready=0 is ignored and must be held by the sender.
- Latency: a result completed at edge t is visible as res_valid=1 after edge t. There is no combinational input-to-output path.
- count:
  - A push alone increments count; a pop alone decrements it.
  - A simultaneous push and pop leaves count unchanged.
  - A push when count==DEPTH cannot occur because psum_ready=0.
  - A pop when empty cannot occur because res_valid=0.
  - A push into an empty FIFO is not visible to the consumer in the same cycle.
- Pointers wrap modulo DEPTH.
- clear mid-group discards the partial sum and all buffered results.

Optional Feature:
- Macro PSUM_SAT_EN.
- Defined: each addition saturates at 2^ACC_W-1. Any saturating add sets sat_flag, which stays 1 until clear.
- Undefined: additions wrap mod 2^ACC_W and sat_flag is tied to 0.

Test Plan:
- Reset: hold clear=1 for 2 cycles with psum_valid=1 -> count=0, res_valid=0, psum_ready=1, sat_flag=0, no push.
- Back-to-back group: psum 100, 200, 300 in consecutive cycles, res_ready=1 -> res_out=600 with res_valid=1 for exactly one cycle, starting the cycle after 300 is accepted.
- Backpressure: res_ready=0, stream 15 psums of value 1 -> 4 results pushed; psum_ready=0 once count=4; 13th psum stalls. Raise res_ready -> drains 3, 3, 3, 3; stalled group then completes and outputs 3; count returns to 0.
- Flush: psums 7 then 8, then flush alone -> result 15. Next group 1, 2, 3 -> result 6. flush together with psum 9 as the first of a group -> result 9.
- Saturation with ACC_W=16: psums 0xFFFF, 0x0002, 0x0000 -> with PSUM_SAT_EN, res_out=0xFFFF and sat_flag=1; without it, res_out=0x0001 and sat_flag=0.
- Mid-group clear: psum 50 accepted, then clear for 1 cycle, then psums 10, 20, 30 -> single result 60, count=1.
